led_reg_ctrl: RTL and testbench
===============================

// Module: led_reg_ctrl
// PURPOSE
//  Transaction controller behind spi_slave in spi_top. Owns the LED brightness register bank.
//  Commits CMD_LED_SET frames when a frame completes. Serves CMD_LED_READ data to the slave's
//  i_tx_payload during the same frame. Keeps sticky error flags and transaction counters.
// PARAMETERS
//  NUM_LEDS   4   number of brightness registers; valid addresses are 0..NUM_LEDS-1
//  CNT_WIDTH  16  width of each transaction/error counter (saturating)
// PORTS
//  sysclk           in   1            system clock, 125 MHz
//  rst_n            in   1            asynchronous active-low reset
//  i_cmd            in   CMD_BITS     spi_slave o_cmd
//  i_addr           in   ADDR_BITS    spi_slave o_addr
//  i_payload        in   PAYLOAD_BITS spi_slave o_payload
//  i_rx_dv          in   1            spi_slave rx_dv; level, high while CS is deasserted
//  i_rd_bypass      in   1            spi_slave rd_bypass
//  i_rx_addr_dv     in   1            spi_slave rx_addr_dv
//  i_clr_err        in   1            pulse; clears sticky errors and error counter
//  o_tx_payload     out  8            to spi_slave i_tx_payload
//  o_led_bright     out  NUM_LEDS*8   flattened bank; LED k is bits [8k+7:8k]
//  o_wr_strobe      out  1            1-cycle pulse when a bank write commits
//  o_wr_idx         out  $clog2(NUM_LEDS)  index of last committed write
//  o_err_addr       out  1            sticky: out-of-range address seen
//  o_err_cmd        out  1            sticky: unknown command seen
//  o_set_cnt        out  CNT_WIDTH    committed LED_SET frames
//  o_rd_cnt         out  CNT_WIDTH    served LED_READ frames
//  o_err_cnt        out  CNT_WIDTH    frames that raised any error
// BEHAVIOUR
//  Reset values
//  - All outputs and the bank are 0.
//  - FSM state is IDLE.
//  - rx_addr_dv edge detector is cleared to 0.
//  FSM states and transitions
//  - IDLE: wait for i_rx_dv==0, then go to ACTIVE. This arms the block; the high level of
//    rx_dv seen after reset never commits.
//  - ACTIVE: on i_rx_dv 0->1 (registered edge detect), go to COMMIT.
//  - COMMIT: one cycle. Decode i_cmd/i_addr/i_payload, which are valid while rx_dv is high,
//    then go to IDLE.
//  Decode in COMMIT
//  - CMD_LED_SET with addr < NUM_LEDS: bank[addr] <= payload, o_wr_strobe=1, o_wr_idx=addr,
//    o_set_cnt++.
//  - CMD_LED_SET with addr >= NUM_LEDS: no write, o_err_addr<=1, o_err_cnt++.
//  - CMD_LED_READ: no write; counting is done in ACTIVE, see read path.
//  - CMD_NOP: no effect.
//  - Any other command: o_err_cmd<=1, o_err_cnt++.
//  Read path
//  - o_tx_payload is combinational, zero latency. Value is bank[i_addr] when i_rd_bypass=1 and
//    i_addr < NUM_LEDS, else 8'h00.
//  - Zero latency is mandatory: the slave samples i_tx_payload the cycle after it raises
//    rx_addr_dv.
//  - While in ACTIVE, an i_rx_addr_dv 0->1 edge does: o_rd_cnt++; if i_addr >= NUM_LEDS then
//    o_err_addr<=1 and o_err_cnt++.
//  - At most one count per frame; the edge detector rearms only after a COMMIT.
//  Counter rules
//  - All counters saturate at all-ones and do not wrap.
//  - At most one o_err_cnt increment per frame, even if both error flags set.
//  Simultaneous events
//  - i_clr_err in the same cycle as a new error: the set wins. Flag ends 1, counter ends 1.
//  - A write in COMMIT and a combinational read of the same address in that cycle: the read
//    returns the old value.
//  Reset mid-frame
//  - Asynchronous return to IDLE, bank cleared, strobes deasserted.
//  - The interrupted frame is never committed: rx_dv must go low again to re-arm.
//  - CS glitch shorter than 3 sysclk: handled by slave sync; no extra filtering here.
// STRUCTURE
//  - params.vh: CMD_BITS/ADDR_BITS/PAYLOAD_BITS, CMD_* and ADDR_NONE/PAYLOAD_NONE macros,
//    plus new localparams for the LED_CTRL FSM state encodings (2 bits).
//  - Sub-module led_bank: NUM_LEDS x 8 register file with one sync write port, one
//    combinational read port, async clear. The FSM, edge detect and counters stay in
//    led_reg_ctrl.
// TESTING (drive through real spi_slave with an SPI master BFM, sclk 26 MHz)
//  1. Post-reset, rx_dv high for 100 cycles -> no o_wr_strobe, all counters 0.
//  2. LED_SET addr 8'h02 data 8'h80 -> single o_wr_strobe, o_wr_idx=2, bank[2]=8'h80,
//     o_set_cnt=1.
//  3. Test 2 then LED_READ addr 8'h02 -> MISO last byte 8'h80, o_rd_cnt=1, bank unchanged.
//  4. LED_SET addr 8'h07 (NUM_LEDS=4) -> no write, o_err_addr=1, o_err_cnt=1. Then i_clr_err
//     -> flags and o_err_cnt return to 0.
//  5. Command 8'h5A -> o_err_cmd=1. i_clr_err in the same cycle as the next bad frame's
//     COMMIT -> flag stays 1.
//  6. rst_n low for 1 cycle mid-ADDRESS of a LED_SET -> bank stays 0, no strobe. The next
//     full frame commits normally.

Source files
------------

// File: rtl/led_reg_ctrl_pkg.sv
// Shared command codes, bus widths and FSM state encoding for the LED
// register controller.
package led_reg_ctrl_pkg;

    localparam int CMD_BITS     = 8;
    localparam int ADDR_BITS    = 8;
    localparam int PAYLOAD_BITS = 8;

    localparam logic [CMD_BITS-1:0] CMD_NOP      = 8'h00;
    localparam logic [CMD_BITS-1:0] CMD_LED_SET  = 8'h01;
    localparam logic [CMD_BITS-1:0] CMD_LED_READ = 8'h02;

    localparam logic [ADDR_BITS-1:0]    ADDR_NONE    = 8'hFF;
    localparam logic [PAYLOAD_BITS-1:0] PAYLOAD_NONE = 8'h00;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_COMMIT = 2'd2
    } led_ctrl_state_t;

endpackage

// File: rtl/led_reg_ctrl_bank.sv
// NUM_LEDS x 8 brightness register file: one synchronous write port,
// one combinational read port, asynchronous clear.
module led_reg_ctrl_bank #(
    parameter int NUM_LEDS = 4,
    parameter int IDX_W    = $clog2(NUM_LEDS)
) (
    input  logic                  sysclk,
    input  logic                  rst_n,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [7:0]            i_wr_data,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [7:0]            o_rd_data,
    output logic [NUM_LEDS*8-1:0] o_flat
);

    logic [7:0] r_bank [NUM_LEDS];

    generate
        for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_reg
            always_ff @(posedge sysclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_bank[gi] <= 8'h00;
                end else if (i_wr_en && (i_wr_idx == IDX_W'(gi))) begin
                    r_bank[gi] <= i_wr_data;
                end
            end
            assign o_flat[8*gi +: 8] = r_bank[gi];
        end
    endgenerate

    // Reads see the pre-write value during the commit cycle.
    assign o_rd_data = r_bank[i_rd_idx];

endmodule

// File: rtl/led_reg_ctrl.sv
// Transaction controller behind the SPI slave: commits LED_SET frames,
// serves LED_READ data with zero latency, keeps sticky errors and counters.
module led_reg_ctrl
    import led_reg_ctrl_pkg::*;
#(
    parameter int NUM_LEDS  = 4,
    parameter int CNT_WIDTH = 16
) (
    input  logic                        sysclk,
    input  logic                        rst_n,
    input  logic [CMD_BITS-1:0]         i_cmd,
    input  logic [ADDR_BITS-1:0]        i_addr,
    input  logic [PAYLOAD_BITS-1:0]     i_payload,
    input  logic                        i_rx_dv,
    input  logic                        i_rd_bypass,
    input  logic                        i_rx_addr_dv,
    input  logic                        i_clr_err,
    output logic [7:0]                  o_tx_payload,
    output logic [NUM_LEDS*8-1:0]       o_led_bright,
    output logic                        o_wr_strobe,
    output logic [$clog2(NUM_LEDS)-1:0] o_wr_idx,
    output logic                        o_err_addr,
    output logic                        o_err_cmd,
    output logic [CNT_WIDTH-1:0]        o_set_cnt,
    output logic [CNT_WIDTH-1:0]        o_rd_cnt,
    output logic [CNT_WIDTH-1:0]        o_err_cnt
);

    localparam int IDX_W = $clog2(NUM_LEDS);
    localparam logic [ADDR_BITS-1:0] ADDR_LIMIT = ADDR_BITS'(NUM_LEDS);

    led_ctrl_state_t r_state, w_state_next;

    logic r_rx_dv_d, r_addr_dv_d, r_rd_armed, r_frame_err;
    logic r_wr_strobe, r_err_addr, r_err_cmd;
    logic [IDX_W-1:0]     r_wr_idx;
    logic [CNT_WIDTH-1:0] r_set_cnt, r_rd_cnt, r_err_cnt;

    logic w_addr_ok, w_wr_en, w_rd_evt, w_rd_addr_err, w_set_addr_err, w_cmd_err;
    logic w_err_inc;
    logic [IDX_W-1:0] w_idx;
    logic [7:0]       w_rd_data;

    assign w_addr_ok = (i_addr < ADDR_LIMIT);
    assign w_idx     = i_addr[IDX_W-1:0];

    always_comb begin
        w_state_next   = r_state;
        w_wr_en        = 1'b0;
        w_rd_evt       = 1'b0;
        w_set_addr_err = 1'b0;
        w_cmd_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!i_rx_dv) w_state_next = ST_ACTIVE;
            end
            ST_ACTIVE: begin
                w_rd_evt = i_rx_addr_dv && !r_addr_dv_d && i_rd_bypass && r_rd_armed;
                if (i_rx_dv && !r_rx_dv_d) w_state_next = ST_COMMIT;
            end
            ST_COMMIT: begin
                w_state_next = ST_IDLE;
                if (i_cmd == CMD_LED_SET) begin
                    w_wr_en        = w_addr_ok;
                    w_set_addr_err = !w_addr_ok;
                end else if (i_cmd != CMD_LED_READ && i_cmd != CMD_NOP) begin
                    w_cmd_err = 1'b1;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    assign w_rd_addr_err = w_rd_evt && !w_addr_ok;
    // A frame whose read already counted an error must not count again at commit.
    assign w_err_inc = w_rd_addr_err || ((w_set_addr_err || w_cmd_err) && !r_frame_err);

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_rx_dv_d   <= 1'b0;
            r_addr_dv_d <= 1'b0;
            r_rd_armed  <= 1'b1;
            r_frame_err <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_idx    <= '0;
            r_err_addr  <= 1'b0;
            r_err_cmd   <= 1'b0;
            r_set_cnt   <= '0;
            r_rd_cnt    <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state     <= w_state_next;
            r_rx_dv_d   <= i_rx_dv;
            r_addr_dv_d <= i_rx_addr_dv;
            r_wr_strobe <= w_wr_en;

            if (r_state == ST_COMMIT) begin
                r_rd_armed  <= 1'b1;
                r_frame_err <= 1'b0;
            end else begin
                if (w_rd_evt)      r_rd_armed  <= 1'b0;
                if (w_rd_addr_err) r_frame_err <= 1'b1;
            end

            if (w_wr_en) begin
                r_wr_idx <= w_idx;
                if (r_set_cnt != '1) r_set_cnt <= r_set_cnt + 1'b1;
            end
            if (w_rd_evt && r_rd_cnt != '1) r_rd_cnt <= r_rd_cnt + 1'b1;

            // New errors take precedence over a simultaneous clear.
            if (w_set_addr_err || w_rd_addr_err) r_err_addr <= 1'b1;
            else if (i_clr_err)                   r_err_addr <= 1'b0;
            if (w_cmd_err)      r_err_cmd <= 1'b1;
            else if (i_clr_err) r_err_cmd <= 1'b0;

            if (i_clr_err)
                r_err_cnt <= w_err_inc ? CNT_WIDTH'(1) : '0;
            else if (w_err_inc && r_err_cnt != '1)
                r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    led_reg_ctrl_bank #(
        .NUM_LEDS (NUM_LEDS),
        .IDX_W    (IDX_W)
    ) u_bank (
        .sysclk    (sysclk),
        .rst_n     (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_idx),
        .i_wr_data (i_payload),
        .i_rd_idx  (w_idx),
        .o_rd_data (w_rd_data),
        .o_flat    (o_led_bright)
    );

    assign o_tx_payload = (i_rd_bypass && w_addr_ok) ? w_rd_data : 8'h00;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_wr_idx     = r_wr_idx;
    assign o_err_addr   = r_err_addr;
    assign o_err_cmd    = r_err_cmd;
    assign o_set_cnt    = r_set_cnt;
    assign o_rd_cnt     = r_rd_cnt;
    assign o_err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_led_reg_ctrl.sv
// Scoreboard bench for led_reg_ctrl: frame-level stimulus feeds a reference
// model and expectation queues; an independent monitor compares DUT outputs.
module tb_led_reg_ctrl;
    import led_reg_ctrl_pkg::*;

    localparam int NL = 4;
    localparam int CW = 4;
    localparam int CMAX = (1 << CW) - 1;

    logic sysclk = 1'b0;
    logic rst_n;
    logic [7:0] i_cmd, i_addr, i_payload;
    logic i_rx_dv, i_rd_bypass, i_rx_addr_dv, i_clr_err;
    logic [7:0]      o_tx_payload;
    logic [NL*8-1:0] o_led_bright;
    logic            o_wr_strobe;
    logic [1:0]      o_wr_idx;
    logic            o_err_addr, o_err_cmd;
    logic [CW-1:0]   o_set_cnt, o_rd_cnt, o_err_cnt;

    always #4 sysclk = ~sysclk;

    led_reg_ctrl #(.NUM_LEDS(NL), .CNT_WIDTH(CW)) dut (
        .sysclk       (sysclk),
        .rst_n        (rst_n),
        .i_cmd        (i_cmd),
        .i_addr       (i_addr),
        .i_payload    (i_payload),
        .i_rx_dv      (i_rx_dv),
        .i_rd_bypass  (i_rd_bypass),
        .i_rx_addr_dv (i_rx_addr_dv),
        .i_clr_err    (i_clr_err),
        .o_tx_payload (o_tx_payload),
        .o_led_bright (o_led_bright),
        .o_wr_strobe  (o_wr_strobe),
        .o_wr_idx     (o_wr_idx),
        .o_err_addr   (o_err_addr),
        .o_err_cmd    (o_err_cmd),
        .o_set_cnt    (o_set_cnt),
        .o_rd_cnt     (o_rd_cnt),
        .o_err_cnt    (o_err_cnt)
    );

    typedef struct { int idx; logic [7:0] data; } wr_t;
    typedef struct { int set_c; int rd_c; int err_c; bit ea; bit ec; logic [NL*8-1:0] bank; } snap_t;

    logic [7:0] rd_q[$];
    wr_t        wr_q[$];
    snap_t      snap_q[$];

    // Reference model
    logic [7:0] m_bank [NL];
    int m_set, m_rd, m_err;
    bit m_ea, m_ec;

    int n_vec = 0;
    int n_err = 0;
    logic frame_done = 1'b0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    task automatic go(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < NL; k++) m_bank[k] = 8'h00;
        m_set = 0; m_rd = 0; m_err = 0; m_ea = 0; m_ec = 0;
    endtask

    task automatic push_snap();
        snap_t s;
        s.set_c = m_set; s.rd_c = m_rd; s.err_c = m_err; s.ea = m_ea; s.ec = m_ec;
        for (int k = 0; k < NL; k++) s.bank[8*k +: 8] = m_bank[k];
        snap_q.push_back(s);
        frame_done = 1'b1;
        go(1);
        frame_done = 1'b0;
    endtask

    task automatic frame(input logic [7:0] cmd, input logic [7:0] addr,
                         input logic [7:0] pl, input bit clr_at_commit);
        bit is_rd;
        bit err_this;
        is_rd = (cmd == CMD_LED_READ);
        err_this = 0;
        i_rx_dv = 1'b0;
        go(3);
        i_cmd = cmd; i_addr = addr; i_payload = pl; i_rd_bypass = is_rd;
        if (is_rd) begin
            rd_q.push_back((addr < NL) ? m_bank[addr] : 8'h00);
            m_rd = sat(m_rd);
            if (addr >= NL) begin m_ea = 1; m_err = sat(m_err); err_this = 1; end
            i_rx_addr_dv = 1'b1;
            go(2);
            i_rx_addr_dv = 1'b0;
            go(1);
        end
        i_rx_dv = 1'b1;
        go(1);
        if (clr_at_commit) begin
            i_clr_err = 1'b1;
            m_ea = 0; m_ec = 0; m_err = 0;
        end
        if (cmd == CMD_LED_SET) begin
            if (addr < NL) begin
                wr_t w;
                w.idx = addr; w.data = pl;
                wr_q.push_back(w);
                m_bank[addr] = pl;
                m_set = sat(m_set);
            end else begin
                m_ea = 1;
                if (!err_this) m_err = sat(m_err);
            end
        end else if (cmd != CMD_LED_READ && cmd != CMD_NOP) begin
            m_ec = 1;
            if (!err_this) m_err = sat(m_err);
        end
        go(1);
        i_clr_err = 1'b0;
        go(1);
        i_rd_bypass = 1'b0;
        $display("frame cmd=%02h addr=%02h data=%02h clr=%0b", cmd, addr, pl, clr_at_commit);
        push_snap();
    endtask

    task automatic clr_pulse();
        i_clr_err = 1'b1;
        go(1);
        i_clr_err = 1'b0;
        m_ea = 0; m_ec = 0; m_err = 0;
        $display("clr_err pulse");
        push_snap();
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        i_rx_dv = 1'b1;
        i_rx_addr_dv = 1'b0;
        i_clr_err = 1'b0;
        model_reset();
        go(1);
        rst_n = 1'b1;
        go(hold);
        $display("reset, rx_dv high for %0d cycles", hold);
        push_snap();
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor
    logic prev_adv = 1'b0;
    always @(negedge sysclk) begin
        if (!rst_n) begin
            prev_adv <= 1'b0;
        end else begin
            prev_adv <= i_rx_addr_dv;
            if (i_rx_addr_dv && !prev_adv) begin
                if (rd_q.size() == 0) chk("unexpected_read", 1, 0);
                else chk("tx_payload", int'(o_tx_payload), int'(rd_q.pop_front()));
            end
            if (o_wr_strobe) begin
                if (wr_q.size() == 0) begin
                    chk("unexpected_strobe", 1, 0);
                end else begin
                    wr_t w;
                    w = wr_q.pop_front();
                    chk("wr_idx", int'(o_wr_idx), w.idx);
                    chk("wr_data", int'(o_led_bright[8*w.idx +: 8]), int'(w.data));
                end
            end
            if (frame_done) begin
                if (snap_q.size() == 0) begin
                    chk("snap_queue_empty", 1, 0);
                end else begin
                    snap_t s;
                    s = snap_q.pop_front();
                    chk("set_cnt", int'(o_set_cnt), s.set_c);
                    chk("rd_cnt", int'(o_rd_cnt), s.rd_c);
                    chk("err_cnt", int'(o_err_cnt), s.err_c);
                    chk("err_addr", int'(o_err_addr), int'(s.ea));
                    chk("err_cmd", int'(o_err_cmd), int'(s.ec));
                    chk("bank", int'(o_led_bright), int'(s.bank));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] c, a;
        rst_n = 1'b0;
        i_cmd = 8'h00; i_addr = 8'h00; i_payload = 8'h00;
        i_rx_dv = 1'b1; i_rd_bypass = 1'b0; i_rx_addr_dv = 1'b0; i_clr_err = 1'b0;
        model_reset();
        go(2);

        // Post-reset high rx_dv must not commit
        do_reset(100);

        frame(CMD_LED_SET, 8'h02, 8'h80, 0);
        frame(CMD_LED_READ, 8'h02, 8'h00, 0);
        frame(CMD_LED_SET, 8'h07, 8'h33, 0);
        clr_pulse();
        frame(8'h5A, 8'h01, 8'h11, 0);
        frame(8'h5A, 8'h01, 8'h11, 1);
        frame(CMD_LED_READ, 8'h05, 8'h00, 0);
        frame(CMD_NOP, 8'h01, 8'hFF, 0);

        // Reset in the middle of a LED_SET frame
        i_rx_dv = 1'b0;
        go(3);
        i_cmd = CMD_LED_SET; i_addr = 8'h01; i_payload = 8'h55;
        go(1);
        do_reset(5);
        frame(CMD_LED_SET, 8'h01, 8'h55, 0);

        // Drive the set counter into saturation
        for (int k = 0; k < 17; k++) frame(CMD_LED_SET, 8'(k % NL), 8'($urandom_range(0, 255)), 0);

        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 3))
                0: c = CMD_NOP;
                1: c = CMD_LED_SET;
                2: c = CMD_LED_READ;
                default: c = 8'($urandom_range(3, 255));
            endcase
            a = 8'($urandom_range(0, 7));
            frame(c, a, 8'($urandom_range(0, 255)),
                  (c != CMD_LED_READ) && ($urandom_range(0, 5) == 0));
            if ($urandom_range(0, 9) == 0) clr_pulse();
        end

        go(3);
        chk("wr_q_drained", wr_q.size(), 0);
        chk("rd_q_drained", rd_q.size(), 0);
        chk("snap_q_drained", snap_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
